// File: rtl/window_builder_pkg.sv
// ============================================================================
//  Module      : window_builder_pkg
//  Description : Shared constants for the window builder and the filter
//                datapath that consumes its windows: pixel width, window
//                edge, packed window width and the (row, col) -> bit offset
//                mapping of the packed window.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package window_builder_pkg;

   localparam int PIX_W  = 10;              // bits per pixel
   localparam int K      = 9;               // window edge
   localparam int DATA_W = K * K * PIX_W;   // packed window width (810)

   // Bit offset of window pixel (r, c) inside the packed window.
   // r = 0 is the oldest row, c = 0 the leftmost column.
   function automatic int pix_off(input int r, input int c);
      return PIX_W * (K * r + c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/window_builder_if.sv
// ============================================================================
//  Module      : window_builder_if
//  Description : Pixel-stream / window-bus bundle between the pixel source,
//                the window builder and the filter datapath.
//                  pix_in     : incoming pixel
//                  pix_valid  : pixel accepted this edge (no backpressure)
//                  sof        : start of frame, qualified by pix_valid
//                  data_bus   : packed K x K window
//                  refresh    : one-cycle pulse, data_bus holds a new window
//                  frame_done : one-cycle pulse after last pixel of a frame
//                master = pixel source side, slave = window builder side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface window_builder_if;
   import window_builder_pkg::*;

   logic [PIX_W-1:0]  pix_in;
   logic              pix_valid;
   logic              sof;
   logic [DATA_W-1:0] data_bus;
   logic              refresh;
   logic              frame_done;

   modport master (
      output pix_in,
      output pix_valid,
      output sof,
      input  data_bus,
      input  refresh,
      input  frame_done
   );

   modport slave (
      input  pix_in,
      input  pix_valid,
      input  sof,
      output data_bus,
      output refresh,
      output frame_done
   );

endinterface

`default_nettype wire

// File: rtl/window_builder_line_ram.sv
// ============================================================================
//  Module      : window_builder_line_ram
//  Description : One line buffer: DEPTH x PIX_W memory, synchronous write,
//                asynchronous read. A read and write of the same address in
//                one cycle returns the old contents (read-before-write),
//                which is what makes the line cascade work.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_addr   - shared read/write address
//                i_wdata  - write data
//                o_rdata  - asynchronous read data
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module window_builder_line_ram
   import window_builder_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             i_we,
   input  wire logic [AW-1:0]    i_addr,
   input  wire logic [PIX_W-1:0] i_wdata,
   output logic      [PIX_W-1:0] o_rdata
);

   // Contents are intentionally not reset; row/col gating upstream keeps
   // stale lines out of any flagged window.
   logic [PIX_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/window_builder.sv
// ============================================================================
//  Module      : window_builder
//  Description : Builds a K x K pixel neighbourhood from a raster-order pixel
//                stream using K-1 cascaded line buffers and a K x K window
//                register. Flags every window that lies fully inside the
//                frame with a one-cycle refresh pulse.
//  Ports       : clk  - clock, all logic on rising edge
//                rst  - synchronous active-high reset
//                bus  - window_builder_if.slave (pixel in, window out)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module window_builder
   import window_builder_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  wire logic          clk,
   input  wire logic          rst,
   window_builder_if.slave    bus
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
   localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
   localparam logic [CW-1:0] c_col_min  = CW'(K - 1);
   localparam logic [RW-1:0] c_row_min  = RW'(K - 1);

   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [DATA_W-1:0] r_data;
   logic              r_refresh;
   logic              r_frame_done;

   logic              w_sof;
   logic [CW-1:0]     w_col;
   logic [RW-1:0]     w_row;
   logic [CW-1:0]     w_col_next;
   logic [RW-1:0]     w_row_next;
   logic              w_flag;
   logic              w_last;
   logic [DATA_W-1:0] w_win_next;
   logic [PIX_W-1:0]  w_rd [K-1];

   // A qualified sof forces the accepted pixel to position (0,0), so the
   // line buffers are addressed and the flags decided from the restarted
   // counters within the same cycle.
   assign w_sof = bus.pix_valid & bus.sof;
   assign w_col = w_sof ? '0 : r_col;
   assign w_row = w_sof ? '0 : r_row;

   assign w_flag = (w_row >= c_row_min) && (w_col >= c_col_min);
   assign w_last = (w_row == c_row_last) && (w_col == c_col_last);

   always_comb begin
      w_col_next = w_col + 1'b1;
      w_row_next = w_row;
      if (w_col == c_col_last) begin
         w_col_next = '0;
         w_row_next = (w_row == c_row_last) ? '0 : w_row + 1'b1;
      end
   end

   // Line cascade: buffer 0 takes the new pixel, buffer i takes what buffer
   // i-1 held at this column (read-before-write in the same edge).
   for (genvar gi = 0; gi < K - 1; gi++) begin : g_line
      logic [PIX_W-1:0] w_wdata;
      if (gi == 0) begin : g_head
         assign w_wdata = bus.pix_in;
      end else begin : g_casc
         assign w_wdata = w_rd[gi-1];
      end

      window_builder_line_ram #(
         .DEPTH (IMG_W)
      ) u_ram (
         .clk     (clk),
         .i_we    (bus.pix_valid & ~rst),
         .i_addr  (w_col),
         .i_wdata (w_wdata),
         .o_rdata (w_rd[gi])
      );
   end

   // Window shifts left one column; the new rightmost column is, bottom to
   // top, the incoming pixel followed by line buffers 0 .. K-2.
   always_comb begin
      w_win_next = r_data;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            w_win_next[pix_off(r, c) +: PIX_W] = r_data[pix_off(r, c + 1) +: PIX_W];
         end
         if (r == K - 1) begin
            w_win_next[pix_off(r, K - 1) +: PIX_W] = bus.pix_in;
         end else begin
            w_win_next[pix_off(r, K - 1) +: PIX_W] = w_rd[K - 2 - r];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_data       <= '0;
         r_refresh    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_refresh    <= 1'b0;
         r_frame_done <= 1'b0;
         if (bus.pix_valid) begin
            r_data       <= w_win_next;
            r_refresh    <= w_flag;
            r_frame_done <= w_last;
            r_col        <= w_col_next;
            r_row        <= w_row_next;
         end
      end
   end

   assign bus.data_bus   = r_data;
   assign bus.refresh    = r_refresh;
   assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_window_builder.sv
// ============================================================================
//  Module      : tb_window_builder
//  Description : Directed self-checking bench for window_builder on a
//                16 x 12 frame with pixel value 16*row+col.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_window_builder;
   import window_builder_pkg::*;

   localparam int TW = 16;
   localparam int TH = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;

   window_builder_if bus ();

   window_builder #(
      .IMG_W (TW),
      .IMG_H (TH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // reference stream position and bookkeeping
   int                m_row = 0;
   int                m_col = 0;
   int                n_ref = 0;
   int                n_fd  = 0;
   bit                hold_ok = 1'b0;
   logic [DATA_W-1:0] hold_val = '0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_win(input int r, input int c);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int rr = 0; rr < K; rr++)
         for (int cc = 0; cc < K; cc++)
            w[PIX_W*(K*rr+cc) +: PIX_W] = PIX_W'((16*(r-8+rr) + (c-8+cc)) % 1024);
      return w;
   endfunction

   // One clock: drive inputs, advance the reference position, check outputs.
   task automatic cyc(input bit v, input bit s);
      int r, c;
      bit exp_ref, exp_fd;
      logic [DATA_W-1:0] ew;
      logic [DATA_W-1:0] obs;
      if (v && s) begin
         m_row = 0;
         m_col = 0;
      end
      r = m_row;
      c = m_col;
      bus.pix_valid = v;
      bus.sof       = s;
      bus.pix_in    = v ? PIX_W'((16*r + c) % 1024) : PIX_W'($urandom);
      exp_ref = v && (r >= K-1) && (c >= K-1);
      exp_fd  = v && (r == TH-1) && (c == TW-1);
      if (v) begin
         if (m_col == TW-1) begin
            m_col = 0;
            m_row = (m_row == TH-1) ? 0 : m_row + 1;
         end else begin
            m_col = m_col + 1;
         end
      end
      @(posedge clk);
      #1;
      chk($sformatf("refresh@%0d,%0d v%0d", r, c, v), DATA_W'(bus.refresh), DATA_W'(exp_ref));
      chk($sformatf("frame_done@%0d,%0d v%0d", r, c, v), DATA_W'(bus.frame_done), DATA_W'(exp_fd));
      if (exp_ref) begin
         ew = ref_win(r, c);
         chk($sformatf("window@%0d,%0d", r, c), bus.data_bus, ew);
         if (r == 8 && c == 8) begin
            obs = bus.data_bus;
            chk("first_win_oldest", DATA_W'(obs[9:0]), DATA_W'(0));
            chk("first_win_newest", DATA_W'(obs[809:800]), DATA_W'(136));
         end
         n_ref++;
         hold_ok  = 1'b1;
         hold_val = ew;
      end else if (v) begin
         hold_ok = 1'b0;
      end else if (hold_ok) begin
         chk($sformatf("hold@%0d,%0d", r, c), bus.data_bus, hold_val);
      end
      if (exp_fd) n_fd++;
   endtask

   task automatic run_pixels(input int npix, input bit gaps, input bit sof_first);
      int sent;
      bit v, s;
      sent = 0;
      while (sent < npix) begin
         v = gaps ? ($urandom_range(0, 99) >= 40) : 1'b1;
         if (v) begin
            s = sof_first && (sent == 0);
            sent++;
         end else begin
            s = 1'($urandom_range(0, 1));
         end
         cyc(v, s);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bus"}, bus.data_bus, '0);
      chk({tag, "_refresh"}, DATA_W'(bus.refresh), '0);
      chk({tag, "_frame_done"}, DATA_W'(bus.frame_done), '0);
   endtask

   initial begin
      // reset held two cycles with pixels offered
      rst = 1'b1;
      bus.pix_valid = 1'b1;
      bus.sof       = 1'b0;
      bus.pix_in    = 10'd123;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk_zero("reset");
      end
      rst = 1'b0;

      // continuous frame
      n_ref = 0; n_fd = 0;
      run_pixels(TW*TH, 1'b0, 1'b1);
      chk("frame1_refreshes", DATA_W'(n_ref), DATA_W'(32));
      chk("frame1_frame_done", DATA_W'(n_fd), DATA_W'(1));

      // back-to-back second frame with sof and random idle gaps
      n_ref = 0; n_fd = 0;
      run_pixels(TW*TH, 1'b1, 1'b1);
      chk("frame2_refreshes", DATA_W'(n_ref), DATA_W'(32));
      chk("frame2_frame_done", DATA_W'(n_fd), DATA_W'(1));

      // sof re-asserted at row 5, col 3
      n_ref = 0; n_fd = 0;
      run_pixels(5*TW + 3, 1'b0, 1'b1);
      chk("pre_sof_refreshes", DATA_W'(n_ref), DATA_W'(0));
      run_pixels(TW*TH, 1'b0, 1'b1);
      chk("sof_restart_refreshes", DATA_W'(n_ref), DATA_W'(32));
      chk("sof_restart_frame_done", DATA_W'(n_fd), DATA_W'(1));

      // reset pulsed at row 9, next frame starts without sof
      run_pixels(9*TW + 5, 1'b0, 1'b1);
      rst = 1'b1;
      bus.pix_valid = 1'b1;
      bus.sof       = 1'b0;
      bus.pix_in    = 10'd77;
      @(posedge clk);
      #1;
      chk_zero("midreset");
      rst = 1'b0;
      m_row = 0; m_col = 0;
      hold_ok = 1'b0;
      n_ref = 0; n_fd = 0;
      run_pixels(TW*TH, 1'b0, 1'b0);
      chk("post_reset_refreshes", DATA_W'(n_ref), DATA_W'(32));
      chk("post_reset_frame_done", DATA_W'(n_fd), DATA_W'(1));

      // idle tail
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
